// File: rtl/calc_input_pkg.sv
// Channel map and default timing for the calculator front-end input conditioner.
package calc_input_pkg;

  localparam int CH_SEL1 = 0;
  localparam int CH_SEL2 = 1;
  localparam int CH_SEL3 = 2;
  localparam int CH_SEL4 = 3;
  localparam int CH_EQ   = 4;
  localparam int CH_DIV  = 5;
  localparam int CH_MUL  = 6;
  localparam int CH_SUB  = 7;
  localparam int CH_ADD  = 8;

  localparam int N_IN = CH_ADD + 1;

  // 10 ms, 500 ms and 200 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 50_000_000;
  localparam int REPEAT_PERIOD_DEF   = 20_000_000;

  localparam int TIMER_W = 27;

  localparam logic [N_IN-1:0] DIGIT_MASK =
    N_IN'((1 << CH_SEL1) | (1 << CH_SEL2) | (1 << CH_SEL3) | (1 << CH_SEL4));

endpackage

// File: rtl/calc_input_conditioner_debounce_channel.sv
// One input channel: two-flop synchroniser, stability counter and debounced level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = calc_input_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             meta_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= raw;
      sync_p1 <= meta_p0;
    end
  end

  // rise/fall announce the level change one cycle ahead of clean
  assign flip = (sync_p1 != clean) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise = flip & ~clean;
  assign fall = flip & clean;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (sync_p1 == clean) begin
      cnt <= '0;
    end else if (flip) begin
      cnt   <= '0;
      clean <= ~clean;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/calc_input_conditioner.sv
// Debounces switches/buttons, queues one pulse per press (plus digit auto-repeat)
// and drains them lowest channel first, one per cycle.
module calc_input_conditioner #(
  parameter int N_IN                    = calc_input_pkg::N_IN,
  parameter int DEBOUNCE_CYCLES         = calc_input_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY            = calc_input_pkg::REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD           = calc_input_pkg::REPEAT_PERIOD_DEF,
  parameter logic [N_IN-1:0] REPEAT_MASK = calc_input_pkg::DIGIT_MASK
) (
  input  logic            clock_100Mhz,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean_level,
  output logic [N_IN-1:0] press_pulse,
  output logic [3:0]      press_index,
  output logic            any_active
);

  import calc_input_pkg::*;

  function automatic logic [N_IN-1:0] lowest_bit(input logic [N_IN-1:0] v);
    lowest_bit = v & (~v + {{(N_IN-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [3:0] onehot_index(input logic [N_IN-1:0] oh);
    onehot_index = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (oh[i]) onehot_index = onehot_index | 4'(i);
    end
  endfunction

  logic [N_IN-1:0]    rise;
  logic [N_IN-1:0]    fall;
  logic [N_IN-1:0]    pending;
  logic [N_IN-1:0]    grant;
  logic [N_IN-1:0]    held_next;
  logic               held_chg;
  logic [N_IN-1:0]    rpt_fire;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock_100Mhz(clock_100Mhz),
      .reset       (reset),
      .raw         (raw_in[g]),
      .clean       (clean_level[g]),
      .rise        (rise[g]),
      .fall        (fall[g])
    );
  end

  assign any_active = |clean_level;

  // Held set as it will be after this edge; any change restarts the repeat timer
  assign held_next = (clean_level ^ (rise | fall)) & REPEAT_MASK;
  assign held_chg  = |((rise | fall) & REPEAT_MASK);

  // After the first repeat the timer reloads so the next terminal count is one period away
  always_comb begin
    timer_next = '0;
    rpt_fire   = '0;
    if (held_next != '0 && !held_chg) begin
      if (timer == TIMER_W'(REPEAT_DELAY - 1))
        timer_next = TIMER_W'(REPEAT_DELAY - REPEAT_PERIOD);
      else
        timer_next = timer + TIMER_W'(1);
      if (timer_next == TIMER_W'(REPEAT_DELAY - 1))
        rpt_fire = lowest_bit(held_next);
    end
  end

  assign grant = lowest_bit(pending);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      timer       <= '0;
      press_pulse <= '0;
      press_index <= '0;
    end else begin
      pending     <= (pending & ~grant) | rise | rpt_fire;
      timer       <= timer_next;
      press_pulse <= grant;
      press_index <= onehot_index(grant);
    end
  end

endmodule

// File: tb/tb_calc_input_conditioner.sv
// Bench for calc_input_conditioner: cycle model compared every cycle plus directed literal checks.
module tb_calc_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam logic [8:0] MASK = 9'h00F;

  logic       clock_100Mhz = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] raw_in = '0;
  logic [8:0] clean_level;
  logic [8:0] press_pulse;
  logic [3:0] press_index;
  logic       any_active;

  calc_input_conditioner #(
    .N_IN           (9),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .raw_in      (raw_in),
    .clean_level (clean_level),
    .press_pulse (press_pulse),
    .press_index (press_index),
    .any_active  (any_active)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  int cyc = 0;
  always @(posedge clock_100Mhz) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] low1(input logic [8:0] v);
    low1 = '0;
    for (int i = 8; i >= 0; i--) if (v[i]) low1 = 9'd1 << i;
  endfunction

  function automatic int low_idx(input logic [8:0] v);
    low_idx = 0;
    for (int i = 8; i >= 0; i--) if (v[i]) low_idx = i;
  endfunction

  // Behavioural model: a level is accepted after D consecutive differing samples;
  // repeats fire at age RD-1, RD-1+RP, ... where age counts cycles since the held set last changed.
  logic [8:0] m_s1 = '0, m_sync = '0, m_clean = '0, m_pend = '0, m_pulse = '0, m_held = '0;
  int m_idx = 0;
  int m_age = 0;
  int m_run [9];

  always @(posedge clock_100Mhz or posedge reset) begin : model
    logic [8:0] nc, nh, fire, grant;
    if (reset) begin
      m_s1 = '0; m_sync = '0; m_clean = '0; m_pend = '0; m_pulse = '0; m_held = '0;
      m_idx = 0; m_age = 0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      nc = m_clean;
      for (int i = 0; i < 9; i++) begin
        if (m_sync[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            nc[i] = ~nc[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      nh = nc & MASK;
      fire = '0;
      if (nh != m_held) m_age = 0;
      else if (nh != '0) begin
        m_age++;
        if (m_age == RD - 1 || (m_age > RD - 1 && (m_age - (RD - 1)) % RP == 0)) fire = low1(nh);
      end
      grant   = low1(m_pend);
      m_pulse = grant;
      m_idx   = (grant != '0) ? low_idx(grant) : 0;
      m_pend  = (m_pend & ~grant) | (nc & ~m_clean) | fire;
      m_held  = nh;
      m_clean = nc;
      m_sync  = m_s1;
      m_s1    = raw_in;
    end
  end

  always @(negedge clock_100Mhz) begin
    if (chk_on) begin
      check("clean_level", 32'(clean_level), 32'(m_clean));
      check("press_pulse", 32'(press_pulse), 32'(m_pulse));
      check("press_index", 32'(press_index), 32'(m_idx));
      check("any_active",  32'(any_active),  32'(|m_clean));
    end
  end

  // Event logs of DUT activity for the directed checks
  int p_cyc[$];
  logic [8:0] p_val[$];
  int p_idx[$];
  int c_cyc[$];
  int c_ch[$];
  logic c_val[$];
  logic [8:0] prev_clean = '0;

  always @(negedge clock_100Mhz) begin
    if (chk_on) begin
      if (press_pulse != '0) begin
        p_cyc.push_back(cyc); p_val.push_back(press_pulse); p_idx.push_back(int'(press_index));
      end
      for (int i = 0; i < 9; i++) begin
        if (clean_level[i] != prev_clean[i]) begin
          c_cyc.push_back(cyc); c_ch.push_back(i); c_val.push_back(clean_level[i]);
        end
      end
      prev_clean = clean_level;
    end
  end

  function automatic int find_clean(input int ch, input logic v);
    find_clean = -1;
    for (int i = c_cyc.size() - 1; i >= 0; i--)
      if (c_ch[i] == ch && c_val[i] == v) find_clean = c_cyc[i];
  endfunction

  task automatic clear_logs();
    p_cyc.delete(); p_val.delete(); p_idx.delete();
    c_cyc.delete(); c_ch.delete(); c_val.delete();
  endtask

  task automatic drive(input logic [8:0] v);
    @(posedge clock_100Mhz);
    #1 raw_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock_100Mhz);
    #1;
  endtask

  int e, e0;

  initial begin
    #2 reset = 1'b1;
    chk_on = 1'b1;
    idle(3);
    check("reset_clean", 32'(clean_level), 32'h0);
    check("reset_pulse", 32'(press_pulse), 32'h0);
    check("reset_index", 32'(press_index), 32'h0);
    check("reset_any",   32'(any_active),  32'h0);
    reset = 1'b0;
    idle(3);

    // Bounce on channel 0
    clear_logs();
    drive(9'h001); drive(9'h000); drive(9'h001); drive(9'h000); drive(9'h001);
    e = cyc;
    idle(9);
    check("bounce_rise_cyc", 32'(find_clean(0, 1'b1)), 32'(e + 6));
    check("bounce_npulse",   32'(p_cyc.size()), 32'd1);
    if (p_cyc.size() == 1) begin
      check("bounce_pulse_cyc", 32'(p_cyc[0]), 32'(e + 7));
      check("bounce_pulse_val", 32'(p_val[0]), 32'h001);
      check("bounce_pulse_idx", 32'(p_idx[0]), 32'd0);
    end
    drive(9'h000);
    idle(10);

    // Three-cycle glitch on channel 5
    clear_logs();
    drive(9'h020);
    idle(2);
    drive(9'h000);
    idle(12);
    check("glitch_clean_chg", 32'(c_cyc.size()), 32'd0);
    check("glitch_npulse",    32'(p_cyc.size()), 32'd0);

    // Simultaneous rises on 0, 4, 8
    clear_logs();
    drive(9'h111);
    e = cyc;
    idle(9);
    drive(9'h000);
    idle(12);
    check("simul_npulse", 32'(p_cyc.size()), 32'd3);
    if (p_cyc.size() == 3) begin
      check("simul_cyc0", 32'(p_cyc[0]), 32'(e + 7));
      check("simul_cyc2", 32'(p_cyc[2]), 32'(e + 9));
      check("simul_val0", 32'(p_val[0]), 32'h001);
      check("simul_val1", 32'(p_val[1]), 32'h010);
      check("simul_val2", 32'(p_val[2]), 32'h100);
      check("simul_idx1", 32'(p_idx[1]), 32'd4);
      check("simul_idx2", 32'(p_idx[2]), 32'd8);
    end

    // Auto-repeat on digit channel 2, held 60 cycles
    clear_logs();
    drive(9'h004);
    e = cyc;
    idle(59);
    drive(9'h000);
    idle(12);
    check("rpt_npulse", 32'(p_cyc.size()), 32'd7);
    if (p_cyc.size() == 7) begin
      check("rpt_first_cyc",  32'(p_cyc[0]), 32'(e + 7));
      check("rpt_second_cyc", 32'(p_cyc[1]), 32'(e + 26));
      check("rpt_last_cyc",   32'(p_cyc[6]), 32'(e + 66));
      for (int i = 2; i < 7; i++) check("rpt_spacing", 32'(p_cyc[i] - p_cyc[i-1]), 32'd8);
      for (int i = 0; i < 7; i++) check("rpt_val", 32'(p_val[i]), 32'h004);
    end

    // Channel 8 is outside the repeat mask
    clear_logs();
    drive(9'h100);
    e = cyc;
    idle(59);
    drive(9'h000);
    idle(12);
    check("norpt_npulse", 32'(p_cyc.size()), 32'd1);
    if (p_cyc.size() == 1) begin
      check("norpt_cyc", 32'(p_cyc[0]), 32'(e + 7));
      check("norpt_idx", 32'(p_idx[0]), 32'd8);
    end

    // Reset while channels 6,7 are pending and channel 1 holds the repeat timer
    clear_logs();
    drive(9'h002);
    e0 = cyc;
    idle(9);
    drive(9'h0C2);
    e = cyc;
    idle(5);
    @(posedge clock_100Mhz);
    #1;
    check("midrst_model_pend", 32'(m_pend), 32'h0C0);
    check("midrst_first_cyc", 32'(p_cyc.size() > 0 ? p_cyc[0] : -1), 32'(e0 + 7));
    #1 reset = 1'b1;
    raw_in = '0;
    #1;
    check("midrst_clean", 32'(clean_level), 32'h0);
    check("midrst_pulse", 32'(press_pulse), 32'h0);
    check("midrst_index", 32'(press_index), 32'h0);
    check("midrst_any",   32'(any_active),  32'h0);
    idle(2);
    reset = 1'b0;
    clear_logs();
    idle(20);
    check("postrst_npulse", 32'(p_cyc.size()), 32'd0);
    check("postrst_clean",  32'(c_cyc.size()), 32'd0);
    drive(9'h008);
    e = cyc;
    idle(9);
    drive(9'h000);
    idle(12);
    check("postrst_press_n", 32'(p_cyc.size()), 32'd1);
    if (p_cyc.size() == 1) begin
      check("postrst_press_cyc", 32'(p_cyc[0]), 32'(e + 7));
      check("postrst_press_val", 32'(p_val[0]), 32'h008);
    end

    // Release of channel 1
    clear_logs();
    drive(9'h002);
    e = cyc;
    idle(9);
    check("rel_any_high", 32'(any_active), 32'd1);
    drive(9'h000);
    idle(12);
    check("rel_rise_cyc", 32'(find_clean(1, 1'b1)), 32'(e + 6));
    check("rel_fall_cyc", 32'(find_clean(1, 1'b0)), 32'(e + 16));
    check("rel_npulse",   32'(p_cyc.size()), 32'd1);
    check("rel_any_low",  32'(any_active), 32'd0);
    check("rel_clean",    32'(clean_level), 32'h0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
